// File: rtl/adder_arb_pkg.sv
// adder_arbiter shared definitions.
// Buffer state, sizing constants and helpers.
package adder_arb_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int NREQ_MAX   = 8;
  localparam int DW_MAX     = 64;
  localparam int EXT_W      = NREQ_MAX * DW_MAX;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Operand idx of width w from a packed
  // vector; caller truncates to w bits.
  function automatic logic [DW_MAX-1:0] opnd_slice(
    input logic [EXT_W-1:0] v,
    input int unsigned      idx,
    input int unsigned      w
  );
    logic [EXT_W-1:0] s;
    s = v >> (idx * w);
    return s[DW_MAX-1:0];
  endfunction

endpackage

// File: rtl/adder.sv
// Plain combinational adder shared by all
// requesters; carry out is the caller's job.
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] out
);

  assign out = in1 + in2;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans from i_ptr upward with wrap.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  // first requester at or after i_ptr wins
  always_comb begin
    int v_idx;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    v_idx     = 0;
    for (int k = 0; k < N; k++) begin
      v_idx = int'(i_ptr) + k;
      if (v_idx >= N) v_idx = v_idx - N;
      if (!o_any && i_req[v_idx]) begin
        o_any     = 1'b1;
        o_gnt_idx = IW'(v_idx);
      end
    end
    if (o_any && i_en) o_gnt[o_gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one adder with a
// one-entry response buffer. ADDER_ARB_OVF_EN adds carry/overflow.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEFAULT,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [DW-1:0]     rsp_sum
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic              rsp_cout,
  output logic              rsp_ovf
`endif
);

  buf_e            r_state;
  buf_e            w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [DW-1:0]   r_sum;
  logic            w_en;
  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_any;
  logic            w_fire;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [EXT_W-1:0] w_a_ext;
  logic [EXT_W-1:0] w_b_ext;
  logic [DW-1:0]   w_a;
  logic [DW-1:0]   w_b;
  logic [DW-1:0]   w_sum;

  // Reset gates grants so nothing is
  // accepted while rst_n is low.
  assign w_en = (r_state == BUF_EMPTY || rsp_ready) && rst_n;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .i_en      (w_en),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_fire = w_any && w_en;
  assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1))
                   ? '0 : w_gnt_idx + 1'b1;

  assign w_a_ext = EXT_W'(req_a);
  assign w_b_ext = EXT_W'(req_b);
  assign w_a = DW'(opnd_slice(w_a_ext, 32'(w_gnt_idx), DW));
  assign w_b = DW'(opnd_slice(w_b_ext, 32'(w_gnt_idx), DW));

`ifdef ADDER_ARB_OVF_EN
  logic [DW:0] w_sum_x;
  logic        w_cout;
  logic        w_ovf;
  logic        r_cout;
  logic        r_ovf;

  adder #(.W(DW + 1)) u_add (
    .in1 ({1'b0, w_a}),
    .in2 ({1'b0, w_b}),
    .out (w_sum_x)
  );

  assign w_sum  = w_sum_x[DW-1:0];
  assign w_cout = w_sum_x[DW];
  assign w_ovf  = (w_a[DW-1] == w_b[DW-1])
               && (w_sum_x[DW-1] != w_a[DW-1]);

  // flags travel with the registered sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_fire) begin
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign rsp_cout = r_cout;
  assign rsp_ovf  = r_ovf;
`else
  adder #(.W(DW)) u_add (
    .in1 (w_a),
    .in2 (w_b),
    .out (w_sum)
  );
`endif

  // buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BUF_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // fill on fire, drain when consumed
  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_fire:               w_state_nxt = BUF_FULL;
      !w_fire && rsp_ready: w_state_nxt = BUF_EMPTY;
      default:              w_state_nxt = r_state;
    endcase
  end

  // buffer and grant outputs
  always_comb begin
    rsp_valid = (r_state == BUF_FULL);
    req_ready = w_gnt;
  end

  // capture result and advance pointer on fire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_sum <= '0;
    end else if (w_fire) begin
      r_ptr <= w_ptr_nxt;
      r_id  <= w_gnt_idx;
      r_sum <= w_sum;
    end
  end

  assign rsp_id  = r_id;
  assign rsp_sum = r_sum;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for
// adder_arbiter (both macro builds).
module tb_adder_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_sum;
`ifdef ADDER_ARB_OVF_EN
  logic         rsp_cout;
  logic         rsp_ovf;
`endif

  int total;
  int bad;

  adder_arbiter u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
`ifdef ADDER_ARB_OVF_EN
    ,
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #3;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    total++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 32'h0 || rsp_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_rsp got v=%b id=%0d s=%h exp 0", rsp_valid, rsp_id, rsp_sum);
    end
    tick();
    tick();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold got v=%b rdy=%b exp 0", rsp_valid, req_ready);
    end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    req_a[31:0] = 32'h3;
    req_b[31:0] = 32'h4;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 32'h7) begin
      bad++;
      $display("FAIL single_rsp got v=%b id=%0d s=%h exp v=1 id=0 s=00000007", rsp_valid, rsp_id, rsp_sum);
    end
  endtask

  task automatic test_wrap();
    req_a[31:0] = 32'hFFFF_FFFF;
    req_b[31:0] = 32'h2;
    #1;
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 32'h1) begin
      bad++;
      $display("FAIL wrap_sum got v=%b s=%h exp v=1 s=00000001", rsp_valid, rsp_sum);
    end
`ifdef ADDER_ARB_OVF_EN
    total++;
    if (rsp_cout !== 1'b1 || rsp_ovf !== 1'b0) begin
      bad++;
      $display("FAIL wrap_flags got c=%b o=%b exp c=1 o=0", rsp_cout, rsp_ovf);
    end
`endif
    req_a[31:0] = 32'h7FFF_FFFF;
    req_b[31:0] = 32'h1;
    #1;
    tick();
    total++;
    if (rsp_sum !== 32'h8000_0000) begin
      bad++;
      $display("FAIL ovf_sum got=%h exp=80000000", rsp_sum);
    end
`ifdef ADDER_ARB_OVF_EN
    total++;
    if (rsp_cout !== 1'b0 || rsp_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_flags got c=%b o=%b exp c=0 o=1", rsp_cout, rsp_ovf);
    end
`endif
    req_valid = '0;
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain got v=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    req_a[95:64] = 32'h3;
    req_b[95:64] = 32'h4;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h7) begin
      bad++;
      $display("FAIL mid_pre got v=%b id=%0d s=%h exp v=1 id=2 s=00000007", rsp_valid, rsp_id, rsp_sum);
    end
    #2;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 32'h0) begin
      bad++;
      $display("FAIL mid_rst got v=%b id=%0d s=%h exp 0", rsp_valid, rsp_id, rsp_sum);
    end
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL mid_ready got=%b exp=0000", req_ready);
    end
    tick();
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_rr();
    logic [31:0] exp_sum [4];
    exp_sum = '{32'h101, 32'h202, 32'h303, 32'h404};
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'h100 * (i + 1);
      req_b[i*32 +: 32] = 32'(i + 1);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rr_first got=%b exp=0001", req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== exp_sum[k % 4]) begin
        bad++;
        $display("FAIL rr_%0d got v=%b id=%0d s=%h exp v=1 id=%0d s=%h", k, rsp_valid, rsp_id, rsp_sum, k % 4, exp_sum[k % 4]);
      end
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0010;
    #1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'h202) begin
        bad++;
        $display("FAIL bp_%0d got rdy=%b v=%b id=%0d s=%h exp rdy=0000 v=1 id=1 s=00000202", c, req_ready, rsp_valid, rsp_id, rsp_sum);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL bp_release got=%b exp=0100", req_ready);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h303) begin
      bad++;
      $display("FAIL bp_next got v=%b id=%0d s=%h exp v=1 id=2 s=00000303", rsp_valid, rsp_id, rsp_sum);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_sparse();
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL sparse_g1 got=%b exp=0010", req_ready);
    end
    tick();
    total++;
    if (rsp_id !== 2'd1 || rsp_sum !== 32'h202) begin
      bad++;
      $display("FAIL sparse_r1 got id=%0d s=%h exp id=1 s=00000202", rsp_id, rsp_sum);
    end
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL sparse_g2 got=%b exp=0100", req_ready);
    end
    tick();
    total++;
    if (rsp_id !== 2'd2 || rsp_sum !== 32'h303) begin
      bad++;
      $display("FAIL sparse_r2 got id=%0d s=%h exp id=2 s=00000303", rsp_id, rsp_sum);
    end
    req_valid = '0;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL idle_ready got=%b exp=0000", req_ready);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_drain got v=%b exp=0", rsp_valid);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    tick();
    test_single();
    test_wrap();
    test_reset_mid();
    test_rr();
    test_backpressure();
    test_sparse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit combinational adder (`adder`, ports in1/in2/out) between NREQ requesters.
- Requesters present operand pairs with a valid/ready handshake.
- A round-robin arbiter picks one request per cycle; the sum is registered into a single-entry response buffer tagged with the requester index.
- Sits between the multi-cycle CPU control (PC/branch-target/address units) and the shared adder, replacing per-unit adders.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 32, operand/result width
- IDW, 2, width of requester index; must equal clog2(NREQ)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_a  in  NREQ*DW  operand A, requester i at bits [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing
- rsp_valid  out  1  response buffer holds a result
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  IDW  index of the requester that produced rsp_sum
- rsp_sum  out  DW  registered sum

Behaviour:
- Reset (rst_n low, async): rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_sum=0. req_ready is all zero while rst_n is low. Reset mid-transaction discards any buffered response.
- Buffer state: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, wrapping modulo NREQ. The first set bit is gnt.
  - req_ready[gnt]=can_accept; all other req_ready bits are 0.
  - If no request is valid, req_ready=0.
  - req_ready may depend on req_valid. req_valid must not depend on req_ready.
- Fire = req_valid[gnt] && req_ready[gnt]. On fire, at the clock edge:
  - rsp_sum <= a[gnt] + b[gnt], modulo 2^DW; carry is discarded.
  - rsp_id <= gnt; rsp_valid <= 1.
  - rr_ptr <= (gnt+1) mod NREQ.
- Latency: result is visible on rsp_* one cycle after fire. Throughput is one add per cycle while rsp_ready=1.
- If no fire and rsp_ready=1 while FULL: rsp_valid <= 0.
- Simultaneous drain and fire (FULL, rsp_ready=1, a request valid): the new result replaces the old in the same edge and rsp_valid stays 1. No bubble.
- Backpressure (FULL, rsp_ready=0): req_ready=0. rsp_sum, rsp_id and rsp_valid hold stable. rr_ptr holds.
- rr_ptr changes only on fire. A requester that holds valid is granted within NREQ fires (starvation-free).
- Requesters must hold operands stable while valid && !ready.

Optional Feature:
- Macro ADDER_ARB_OVF_EN.
- Defined:
  - Adds outputs rsp_cout (1 bit, unsigned carry out of bit DW-1) and rsp_ovf (1 bit, signed overflow: operands share a sign and the sum sign differs).
  - Both are registered alongside rsp_sum and reset to 0.
  - The add is performed DW+1 wide internally.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package adder_arb_pkg holds:
  - localparams DW_DEFAULT=32 and NREQ_MAX=8
  - function clog2
  - the operand-slice helper
- One natural sub-module: rr_arbiter. Inputs are req vector, ptr and enable. Outputs are one-hot gnt and encoded gnt_idx. It is purely combinational and reusable by other shared-resource blocks.
- Sum is computed by instantiating `adder`.

Test Plan:
- Reset mid-op: FULL with rsp_sum=0x00000007, drop rst_n asynchronously → rsp_valid, rsp_sum and rsp_id read 0 before the next clk edge; req_ready=0 while rst_n=0.
- Single requester: req_valid=0001, a=0x00000003, b=0x00000004, rsp_ready=1 → req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x00000007.
- Wrap-around: a=0xFFFFFFFF, b=0x00000002 → rsp_sum=0x00000001. With ADDER_ARB_OVF_EN: rsp_cout=1, rsp_ovf=0. With a=0x7FFFFFFF, b=1: rsp_ovf=1, rsp_cout=0.
- Round-robin fairness: req_valid=1111 held, rsp_ready=1 → rsp_id sequence 0,1,2,3,0 on consecutive cycles, with no idle cycles between results.
- Backpressure: FULL with rsp_id=1, rsp_ready=0 for 3 cycles, req_valid=0100 → req_ready=0 and rsp_* stable for 3 cycles. Raise rsp_ready → same cycle req_ready=0100; next cycle rsp_id=2 with no gap.
- Sparse requests with pointer: rr_ptr=3, req_valid=0110 → gnt=1, then rr_ptr=2; next fire grants 2.
